apb_wide_register_array: RTL and testbench

APB4 slave holding a parametrised array of 64-bit read/write registers, each accessed as two 32-bit halves, with programmable wait states and an optional atomic 64-bit access mode. It is the generalised successor to the fixed-count generated register blocks. It sits between the APB interconnect and datapath logic that needs wide, coherent control values.

---
 rtl/apb_wide_register_array_if.sv | 40 ++++
 rtl/apb_wide_register_array.sv | 221 ++++++++++++++++++++++
 tb/tb_apb_wide_register_array.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_wide_register_array_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_wide_register_array_if                                    |
// | Description : APB4 bus bundle shared by the wide register array and its     |
// |               requester.                                                    |
// |   psel    : select             (master -> slave)                            |
// |   penable : enable / access    (master -> slave)                            |
// |   pwrite  : 1 = write          (master -> slave)                            |
// |   paddr   : byte address       (master -> slave), ADDRESS_WIDTH bits        |
// |   pwdata  : write data         (master -> slave), 32 bits                   |
// |   pstrb   : write byte strobes (master -> slave), 4 bits                    |
// |   pready  : transfer complete  (slave -> master)                            |
// |   prdata  : read data          (slave -> master), 32 bits                   |
// |   pslverr : transfer error     (slave -> master)                            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface apb_wide_register_array_if #(
  parameter int unsigned ADDRESS_WIDTH = 8
);
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [31:0]              pwdata;
  logic [3:0]               pstrb;
  logic                     pready;
  logic [31:0]              prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_wide_register_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_wide_register_array                                       |
// | Description : APB4 slave holding NUM_REGS 64-bit registers, each accessed   |
// |               as two 32-bit halves (low at 8*i, high at 8*i+4), with        |
// |               programmable wait states.                                     |
// |   i_clk   : clock, rising edge                                              |
// |   i_rst_n : asynchronous active-low reset                                   |
// |   apb     : APB4 slave modport (psel/penable/pwrite/paddr/pwdata/pstrb in,  |
// |             pready/prdata/pslverr out)                                      |
// |   o_value : current contents of all registers                               |
// | Option      : RGGEN_WIDE_REGISTER_ATOMIC_EN enables coherent 64-bit access  |
// |               through a low-word write stage and a high-word read snapshot. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module apb_wide_register_array #(
  parameter int unsigned NUM_REGS          = 8,
  parameter int unsigned ADDRESS_WIDTH     = 8,
  parameter int unsigned WAIT_STATES       = 0,
  parameter logic [63:0] INITIAL_VALUE     = 64'h0,
  parameter bit          ERROR_STATUS      = 1'b0,
  parameter logic [31:0] DEFAULT_READ_DATA = 32'h0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  apb_wide_register_array_if.slave   apb,
  output logic [NUM_REGS-1:0][63:0]  o_value
);

  localparam int unsigned            IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0]             WS         = 3'(WAIT_STATES);
  localparam logic [ADDRESS_WIDTH-1:0] NUM_REGS_A = ADDRESS_WIDTH'(NUM_REGS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pready;

  logic [NUM_REGS-1:0][63:0] value_q, value_d;

  // Replace only the strobed bytes of a word.
  function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                          input logic [31:0] new_word,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ST_ACCESS;
          cnt_d   = 3'd0;
        end
      end
      ST_ACCESS: begin
        if (!apb.psel) begin
          // Master abandoned the transfer: nothing is committed.
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == WS) begin
          pready  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] w_word_addr;
  logic                     w_hit;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_hi;
  logic                     w_wr_commit;
  logic [63:0]              w_live;
  logic [31:0]              w_merged_lo;
  logic [31:0]              w_merged_hi;
  logic [31:0]              w_rd_word;

  assign w_word_addr = apb.paddr >> 3;
  assign w_hit       = (w_word_addr < NUM_REGS_A);
  assign w_idx       = w_word_addr[IDX_W-1:0];
  assign w_hi        = apb.paddr[2];
  assign w_wr_commit = pready && apb.pwrite && w_hit;
  assign w_live      = value_q[w_idx];
  assign w_merged_lo = f_merge(w_live[31:0],  apb.pwdata, apb.pstrb);
  assign w_merged_hi = f_merge(w_live[63:32], apb.pwdata, apb.pstrb);

`ifdef RGGEN_WIDE_REGISTER_ATOMIC_EN
  logic             wstage_valid_q, wstage_valid_d;
  logic [IDX_W-1:0] wstage_idx_q,   wstage_idx_d;
  logic [31:0]      wstage_data_q,  wstage_data_d;
  logic             rstage_valid_q, rstage_valid_d;
  logic [IDX_W-1:0] rstage_idx_q,   rstage_idx_d;
  logic [31:0]      rstage_data_q,  rstage_data_d;
  logic             w_rd_done;

  assign w_rd_done = pready && !apb.pwrite && w_hit;

  always_comb begin
    value_d        = value_q;
    wstage_valid_d = wstage_valid_q;
    wstage_idx_d   = wstage_idx_q;
    wstage_data_d  = wstage_data_q;
    rstage_valid_d = rstage_valid_q;
    rstage_idx_d   = rstage_idx_q;
    rstage_data_d  = rstage_data_q;
    if (w_wr_commit) begin
      if (!w_hi) begin
        // Low half is held back until the matching high half arrives.
        wstage_valid_d = 1'b1;
        wstage_idx_d   = w_idx;
        wstage_data_d  = w_merged_lo;
      end else if (wstage_valid_q && (wstage_idx_q == w_idx)) begin
        value_d[w_idx] = {w_merged_hi, wstage_data_q};
        wstage_valid_d = 1'b0;
      end else begin
        value_d[w_idx][63:32] = w_merged_hi;
      end
    end
    if (w_rd_done && !w_hi) begin
      // Freeze the high half so the following high read is coherent.
      rstage_valid_d = 1'b1;
      rstage_idx_d   = w_idx;
      rstage_data_d  = w_live[63:32];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wstage_valid_q <= 1'b0;
      wstage_idx_q   <= '0;
      wstage_data_q  <= 32'h0;
      rstage_valid_q <= 1'b0;
      rstage_idx_q   <= '0;
      rstage_data_q  <= 32'h0;
    end else begin
      wstage_valid_q <= wstage_valid_d;
      wstage_idx_q   <= wstage_idx_d;
      wstage_data_q  <= wstage_data_d;
      rstage_valid_q <= rstage_valid_d;
      rstage_idx_q   <= rstage_idx_d;
      rstage_data_q  <= rstage_data_d;
    end
  end

  always_comb begin
    if (!w_hi) begin
      w_rd_word = w_live[31:0];
    end else if (rstage_valid_q && (rstage_idx_q == w_idx)) begin
      w_rd_word = rstage_data_q;
    end else begin
      w_rd_word = w_live[63:32];
    end
  end
`else
  always_comb begin
    value_d = value_q;
    if (w_wr_commit) begin
      if (w_hi) begin
        value_d[w_idx][63:32] = w_merged_hi;
      end else begin
        value_d[w_idx][31:0] = w_merged_lo;
      end
    end
  end

  assign w_rd_word = w_hi ? w_live[63:32] : w_live[31:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= {NUM_REGS{INITIAL_VALUE}};
    end else begin
      value_q <= value_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign apb.pready  = pready;
  assign apb.prdata  = !pready ? 32'h0 : (w_hit ? w_rd_word : DEFAULT_READ_DATA);
  assign apb.pslverr = pready && !w_hit && ERROR_STATUS;
  assign o_value     = value_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_wide_register_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_wide_register_array                                    |
// | Description : Self-checking bench for apb_wide_register_array: directed     |
// |               vector table, multi-cycle corner sequences and random         |
// |               traffic against a behavioural register model.                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_apb_wide_register_array;
  localparam int          NR    = 8;
  localparam int          AW    = 8;
  localparam int          WS    = 2;
  localparam logic [63:0] INIT  = 64'h0123_4567_89AB_CDEF;
  localparam bit          ERRS  = 1'b1;
  localparam logic [31:0] DEF   = 32'hBADC_0DE5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0][63:0] value;

  apb_wide_register_array_if #(.ADDRESS_WIDTH(AW)) bus ();

  apb_wide_register_array #(
    .NUM_REGS(NR), .ADDRESS_WIDTH(AW), .WAIT_STATES(WS), .INITIAL_VALUE(INIT),
    .ERROR_STATUS(ERRS), .DEFAULT_READ_DATA(DEF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .apb(bus), .o_value(value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a plain array of register values and the two stages.
  logic [63:0] m_val [NR];
  bit          m_ws_v, m_rs_v;
  int          m_ws_i, m_rs_i;
  logic [31:0] m_ws_d, m_rs_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    int bad;
    bad = -1;
    for (int r = NR - 1; r >= 0; r--) if (value[r] !== m_val[r]) bad = r;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: reg%0d actual=%h required=%h", name, bad, value[bad], m_val[bad]);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_val[r] = INIT;
    m_ws_v = 1'b0; m_rs_v = 1'b0; m_ws_i = 0; m_rs_i = 0; m_ws_d = 32'h0; m_rs_d = 32'h0;
  endtask

  task automatic model_apply(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                             input logic [3:0] st, output logic [31:0] rd, output logic err);
    int idx;
    bit hi;
    idx = int'(addr) / 8;
    hi  = addr[2];
    rd  = 32'h0;
    err = 1'b0;
    if (idx >= NR) begin
      rd  = DEF;
      err = ERRS;
      return;
    end
    if (wr) begin
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_EN
      if (!hi) begin
        m_ws_v = 1'b1; m_ws_i = idx; m_ws_d = merge(m_val[idx][31:0], wd, st);
      end else begin
        if (m_ws_v && m_ws_i == idx) begin
          m_val[idx][31:0] = m_ws_d;
          m_ws_v = 1'b0;
        end
        m_val[idx][63:32] = merge(m_val[idx][63:32], wd, st);
      end
`else
      if (hi) m_val[idx][63:32] = merge(m_val[idx][63:32], wd, st);
      else    m_val[idx][31:0]  = merge(m_val[idx][31:0],  wd, st);
`endif
    end else begin
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_EN
      if (!hi) begin
        rd = m_val[idx][31:0];
        m_rs_v = 1'b1; m_rs_i = idx; m_rs_d = m_val[idx][63:32];
      end else begin
        rd = (m_rs_v && m_rs_i == idx) ? m_rs_d : m_val[idx][63:32];
      end
`else
      rd = hi ? m_val[idx][63:32] : m_val[idx][31:0];
`endif
    end
  endtask

  // One APB transfer; returns at the falling edge where pready is seen,
  // i.e. before the commit edge. Inputs are left asserted so a following
  // call starts its setup phase back-to-back.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output logic [31:0] exp_rd, output logic exp_err, output int lat);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wd; bus.pstrb = st;
    rd = 32'h0; err = 1'b0; exp_rd = 32'h0; exp_err = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    lat = 1;
    while (!bus.pready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.pready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: addr=%h no pready within %0d cycles", addr, lat);
      lat = -1;
    end else begin
      rd  = bus.prdata;
      err = bus.pslverr;
      model_apply(wr, addr, wd, st, exp_rd, exp_err);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  st;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [11];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat;

    vt[0]  = '{1'b0, 8'h04, 32'h0,        4'h0, 1'b1, 32'h0123_4567, 1'b0};
    vt[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 32'h89AB_CDEF, 1'b0};
    vt[2]  = '{1'b0, 8'h40, 32'h0,        4'h0, 1'b1, DEF,           1'b1};
    vt[3]  = '{1'b1, 8'h0C, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 8'h0E, 32'h0,        4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
    vt[5]  = '{1'b1, 8'h3C, 32'h11223344, 4'h3, 1'b0, 32'h0,         1'b0};
    vt[6]  = '{1'b0, 8'h3C, 32'h0,        4'h0, 1'b1, 32'h0123_3344, 1'b0};
    vt[7]  = '{1'b1, 8'h7C, 32'h12345678, 4'hF, 1'b0, 32'h0,         1'b1};
    vt[8]  = '{1'b0, 8'h44, 32'h0,        4'h0, 1'b1, DEF,           1'b1};
    vt[9]  = '{1'b0, 8'h38, 32'h0,        4'h0, 1'b1, 32'h89AB_CDEF, 1'b0};
    vt[10] = '{1'b0, 8'h3D, 32'h0,        4'h0, 1'b1, 32'h0123_3344, 1'b0};

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = 32'h0; bus.pstrb = 4'h0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_model("reset_value");
    chk("reset_pready", 64'(bus.pready), 64'd0);
    chk("reset_prdata", 64'(bus.prdata), 64'd0);
    chk("reset_pslverr", 64'(bus.pslverr), 64'd0);

    // Directed vectors, issued back-to-back
    for (int i = 0; i < 11; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].st, rd, err, erd, eerr, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(WS + 1));
      if (vt[i].chk_rd) chk($sformatf("vec%0d_prdata", i), 64'(rd), 64'(vt[i].exp_rd));
      chk($sformatf("vec%0d_pslverr", i), 64'(err), 64'(vt[i].exp_err));
    end
    idle();
    chk_model("vec_values");
    chk("vec_reg1", value[1], 64'hCAFE_F00D_89AB_CDEF);
    chk("vec_reg7", value[7], 64'h0123_3344_89AB_CDEF);
    chk("idle_prdata", 64'(bus.prdata), 64'd0);

    // Byte strobes on a low word
    xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 4'b0101, rd, err, erd, eerr, lat);
    chk("strobe_latency", 64'(lat), 64'(WS + 1));
    idle();
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_EN
    chk("strobe_staged_only", value[1], 64'hCAFE_F00D_89AB_CDEF);
`else
    chk("strobe_low", 64'(value[1][31:0]), 64'h89AD_CDEF);
`endif
    xfer(1'b1, 8'h0C, 32'h0, 4'b0000, rd, err, erd, eerr, lat);
    idle();
    chk("strobe_final", value[1], 64'hCAFE_F00D_89AD_CDEF);

    // Low-then-high write pair
    xfer(1'b1, 8'h10, 32'h1111_1111, 4'hF, rd, err, erd, eerr, lat);
    idle();
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_EN
    chk("pair_low_held", value[2], INIT);
`else
    chk("pair_low_direct", value[2], 64'h0123_4567_1111_1111);
`endif
    xfer(1'b1, 8'h14, 32'h2222_2222, 4'hF, rd, err, erd, eerr, lat);
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_EN
    chk("pair_before_commit", value[2], INIT);
`endif
    @(negedge clk);
    chk("pair_after_commit", value[2], 64'h2222_2222_1111_1111);
    idle();

    // Read snapshot: low read, high write, high read
    xfer(1'b0, 8'h18, 32'h0, 4'h0, rd, err, erd, eerr, lat);
    chk("snap_low_read", 64'(rd), 64'h89AB_CDEF);
    xfer(1'b1, 8'h1C, 32'h5555_5555, 4'hF, rd, err, erd, eerr, lat);
    xfer(1'b0, 8'h1C, 32'h0, 4'h0, rd, err, erd, eerr, lat);
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_EN
    chk("snap_high_read", 64'(rd), 64'h0123_4567);
`else
    chk("snap_high_read", 64'(rd), 64'h5555_5555);
`endif
    idle();

    // Decode error leaves state alone
    xfer(1'b0, 8'h40, 32'h0, 4'h0, rd, err, erd, eerr, lat);
    chk("decerr_prdata", 64'(rd), 64'(DEF));
    chk("decerr_pslverr", 64'(err), 64'd1);
    idle();
    chk_model("decerr_values");

    // Abort: drop psel during wait states
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h20; bus.pwdata = 32'hAAAA_AAAA; bus.pstrb = 4'hF;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    chk("abort_wait_no_ready", 64'(bus.pready), 64'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_ready", 64'(bus.pready), 64'd0);
    chk_model("abort_no_write");
    xfer(1'b1, 8'h24, 32'h7777_7777, 4'hF, rd, err, erd, eerr, lat);
    chk("abort_next_latency", 64'(lat), 64'(WS + 1));
    idle();
    chk("abort_next_value", value[4], 64'h7777_7777_89AB_CDEF);

    // Reset pulse in the middle of an access
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h2C; bus.pwdata = 32'h9999_9999; bus.pstrb = 4'hF;
    @(negedge clk);
    bus.penable = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rstmid_pready", 64'(bus.pready), 64'd0);
    chk_model("rstmid_values");
    bus.psel = 1'b0; bus.penable = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_model("rstmid_after_release");
    xfer(1'b0, 8'h2C, 32'h0, 4'h0, rd, err, erd, eerr, lat);
    chk("rstmid_next_latency", 64'(lat), 64'(WS + 1));
    chk("rstmid_next_prdata", 64'(rd), 64'h0123_4567);
    idle();

    // Random traffic against the model
    for (int n = 0; n < 200; n++) begin
      int          idx;
      bit          hi, wr;
      logic [AW-1:0] a;
      idx = int'($urandom_range(0, NR));
      hi  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      a   = AW'(idx * 8 + (hi ? 4 : 0) + int'($urandom_range(0, 3)));
      xfer(wr, a, $urandom, 4'($urandom_range(0, 15)), rd, err, erd, eerr, lat);
      chk("rand_latency", 64'(lat), 64'(WS + 1));
      if (!wr) chk($sformatf("rand%0d_prdata@%h", n, a), 64'(rd), 64'(erd));
      chk($sformatf("rand%0d_pslverr@%h", n, a), 64'(err), 64'(eerr));
      @(negedge clk);
      chk_model($sformatf("rand%0d_values", n));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
